uart_rx_ctrl: RTL

APB-facing controller that sequences the UART 8-bit receiver. It generates the receiver's baud tick, drives the receiver enable, and captures completed bytes and error events into a small RX FIFO. It exposes DATA/STATUS/CTRL/DIV registers and an interrupt to the APB bus. It sits between the APB slave decode and the receiver datapath.

---
 rtl/uart_rx_ctrl.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// APB register front-end for the UART 8-bit receiver: baud tick generation,
// receiver enable, capture of received bytes/errors into an RX FIFO, and irq.

module uart_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 3,
  parameter logic [15:0] DIV_RST    = 16'h0000
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        rx_baud_tick,
  output logic        rx_en,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        rx_busy,
  input  logic        rx_err,
  output logic        irq
);

  localparam int unsigned      AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [1:0]       REG_DATA   = 2'd0;
  localparam logic [1:0]       REG_STATUS = 2'd1;
  localparam logic [1:0]       REG_CTRL   = 2'd2;
  localparam logic [1:0]       REG_DIV    = 2'd3;

  logic        access;
  logic        wr_acc;
  logic        rd_acc;
  logic [1:0]  reg_sel;
  logic        wr_status;
  logic        wr_ctrl;
  logic        wr_div;
  logic        rd_data;
  logic        flush;

  logic        rx_enable_q, rx_enable_d;
  logic        irq_en_data_q, irq_en_data_d;
  logic        irq_en_err_q, irq_en_err_d;
  logic [15:0] div_q, div_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;

  logic        done_q, done_prev_q;
  logic        err_q, err_prev_q;
  logic        done_rise;
  logic        err_rise;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             not_empty;
  logic             full;
  logic             push_req;
  logic             push_ok;
  logic             pop_ok;
  logic             overrun_set;

  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;
  logic        irq_q, irq_d;

  logic [31:0] status_word;
  logic [7:0]  fifo_head;
  logic        unused_ok;

  assign access    = PSEL & PENABLE;
  assign wr_acc    = access & PWRITE;
  assign rd_acc    = access & ~PWRITE;
  assign reg_sel   = PADDR[3:2];
  assign wr_status = wr_acc & (reg_sel == REG_STATUS);
  assign wr_ctrl   = wr_acc & (reg_sel == REG_CTRL);
  assign wr_div    = wr_acc & (reg_sel == REG_DIV);
  assign rd_data   = rd_acc & (reg_sel == REG_DATA);
  assign flush     = wr_ctrl & PWDATA[3];
  assign unused_ok = ^{PWDATA[31:16], PADDR[1:0]};

  assign PREADY       = 1'b1;
  assign PSLVERR      = wr_acc & (reg_sel == REG_DATA);
  assign rx_en        = rx_enable_q;
  assign irq          = irq_q;
  assign rx_baud_tick = rx_enable_q & (baud_cnt_q == div_q);

  // Control and divider registers; flush is a strobe and is never stored.
  always_comb begin
    rx_enable_d   = rx_enable_q;
    irq_en_data_d = irq_en_data_q;
    irq_en_err_d  = irq_en_err_q;
    div_d         = div_q;
    if (wr_ctrl) begin
      rx_enable_d   = PWDATA[0];
      irq_en_data_d = PWDATA[1];
      irq_en_err_d  = PWDATA[2];
    end
    if (wr_div) begin
      div_d = PWDATA[15:0];
    end
  end

  // A DIV write restarts the period so the new rate takes effect cleanly.
  always_comb begin
    baud_cnt_d = baud_cnt_q;
    if (wr_div || !rx_enable_q) begin
      baud_cnt_d = 16'h0000;
    end else if (baud_cnt_q == div_q) begin
      baud_cnt_d = 16'h0000;
    end else begin
      baud_cnt_d = baud_cnt_q + 16'h0001;
    end
  end

  assign done_rise = done_q & ~done_prev_q & rx_enable_q;
  assign err_rise  = err_q & ~err_prev_q & rx_enable_q;

  assign not_empty   = (count_q != '0);
  assign full        = (count_q == FULL_CNT);
  assign push_req    = done_rise & ~flush;
  assign pop_ok      = rd_data & not_empty;
  assign push_ok     = push_req & (~full | pop_ok);
  assign overrun_set = push_req & full & ~pop_ok;
  assign fifo_head   = mem_q[rd_ptr_q];

  // Pointer/occupancy bookkeeping; a simultaneous push and pop keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Sticky flags: a set event in the same cycle as a W1C wins.
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (wr_status && PWDATA[2]) begin
      overrun_d = 1'b0;
    end
    if (wr_status && PWDATA[3]) begin
      frame_err_d = 1'b0;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end
    if (err_rise) begin
      frame_err_d = 1'b1;
    end
  end

  assign irq_d = (irq_en_data_q & not_empty) | (irq_en_err_q & (overrun_q | frame_err_q));

  always_comb begin
    status_word              = '0;
    status_word[0]           = not_empty;
    status_word[1]           = full;
    status_word[2]           = overrun_q;
    status_word[3]           = frame_err_q;
    status_word[4]           = rx_busy;
    status_word[8 +: CNT_W]  = count_q;
  end

  always_comb begin
    PRDATA = '0;
    if (rd_acc) begin
      case (reg_sel)
        REG_DATA:   PRDATA = not_empty ? {24'h000000, fifo_head} : 32'h0000_0000;
        REG_STATUS: PRDATA = status_word;
        REG_CTRL:   PRDATA = {29'h0, irq_en_err_q, irq_en_data_q, rx_enable_q};
        default:    PRDATA = {16'h0000, div_q};
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_enable_q   <= 1'b0;
      irq_en_data_q <= 1'b0;
      irq_en_err_q  <= 1'b0;
      div_q         <= DIV_RST;
      baud_cnt_q    <= 16'h0000;
    end else begin
      rx_enable_q   <= rx_enable_d;
      irq_en_data_q <= irq_en_data_d;
      irq_en_err_q  <= irq_en_err_d;
      div_q         <= div_d;
      baud_cnt_q    <= baud_cnt_d;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      done_q      <= 1'b0;
      done_prev_q <= 1'b0;
      err_q       <= 1'b0;
      err_prev_q  <= 1'b0;
    end else begin
      done_q      <= rx_done;
      done_prev_q <= done_q;
      err_q       <= rx_err;
      err_prev_q  <= err_q;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      irq_q       <= irq_d;
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge PCLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

endmodule
